cfa_window5x5: RTL and testbench
================================

Name: cfa_window5x5

Overview:
- Upstream feeder for the CFA gradient stage (equ1).
- Accepts a raster-order stream of raw Bayer pixels, one per valid cycle, and buffers four previous image lines.
- Presents a registered 5x5 neighbourhood on taps e1t1..e5t5 with a one-cycle start pulse per complete window.
- Only windows lying fully inside the image are emitted; there is no border padding.

Parameters:
PIX_W, 12, pixel width in bits
IMG_W, 640, pixels per line (must be at least 5)
IMG_H, 480, lines per frame (must be at least 5)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous active-low reset
sof  input  1  start of frame; qualifies the pixel on pix_in with the same pix_valid
pix_valid  input  1  pix_in holds a valid pixel this cycle
pix_in  input  PIX_W  raw Bayer pixel, raster order
e1t1..e5t5  output  PIX_W each  25 window taps: eR = row (e1 oldest line, e5 current line), tC = column (t1 leftmost/oldest, t5 newest)
start  output  1  one-cycle pulse; taps hold a new valid window
frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted
busy  output  1  high in FILL or RUN

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; col=0, row=0; start=0, frame_done=0, busy=0; all 25 taps=0. Line-buffer contents are don't-care.
- Counters:
  - col counts 0..IMG_W-1; row counts 0..IMG_H-1.
  - Both advance only on accepted pixels.
  - col wraps to 0 and row increments when col=IMG_W-1.
- States:
  - IDLE: pixels ignored unless sof=1 and pix_valid=1. That pixel is taken as (row 0, col 0), then state goes to FILL.
  - FILL: rows 0..3 are being written. Taps shift, start stays 0. On acceptance of (3, IMG_W-1), go to RUN.
  - RUN: rows 4..IMG_H-1. start=1 on the cycle after accepting pixel (r,c) with c>=4.
  - DONE: after accepting (IMG_H-1, IMG_W-1), frame_done=1 for exactly one cycle with state transitioning to IDLE. The final window's start and frame_done assert in the same cycle.
- Window construction, on each accepted pixel at column c:
  - Rows 1..4 read line buffers LB3..LB0 at address c.
  - Row 5 is pix_in.
  - The five values shift into the per-row 5-deep column registers: t1<=t2 ... t4<=t5, t5<=new.
  - LB0 <= pix_in at c; LBk <= old LB(k-1) at c.
  - Line buffers are IMG_W deep. Implementation may be register arrays or inferred single-port RAM with read-before-write.
- Latency: taps and start are registered, 1 cycle after the completing pixel.
  - When pix_valid=0, taps hold their values and start=0.
  - Gaps of any length are allowed mid-line.
- Window count per frame: (IMG_W-4)*(IMG_H-4).
- Column registers are not cleared at line wrap. Windows with c<4 are suppressed, so stale data never escapes.
- sof=1 with pix_valid=1 in FILL, RUN or DONE aborts the frame:
  - Counters restart at (0,0) with this pixel.
  - State=FILL, start=0 that cycle.
  - No frame_done is issued for the aborted frame.
- sof=1 with pix_valid=0 is ignored.
- Reset asserted mid-frame clears everything immediately. Output resumes only after a new sof.
- No backpressure: the downstream stage accepts a window every cycle start is high.
- Widths: no arithmetic on pixel data; taps are exact copies of input pixels.
- Counters are clog2(IMG_W) and clog2(IMG_H) wide, with no overflow past the terminal values.

Test Plan:
1. IMG_W=8, IMG_H=6, continuous pix_valid, pixel=(row<<4)|col.
   - First start follows pixel (4,4): e1t1=0x000, e3t3=0x022, e5t5=0x044, e1t5=0x004, e5t1=0x040.
   - Exactly 8 start pulses.
   - frame_done coincides with the last start, whose window has e5t5=0x057.
2. Same image with pix_valid toggling 1,0,0,1.
   - Identical tap sequence and 8 start pulses.
   - Taps stable and start=0 during gaps.
3. At line wrap (5,0)..(5,3): no start.
   - Next start follows (5,4) with e1t1=0x010, e5t5=0x054.
4. sof reasserted at pixel 20 of frame 1, then a full frame 2 with pixel=0x800|(row<<4)|col.
   - No frame_done for frame 1.
   - First frame-2 window has e1t1=0x800, e5t5=0x844.
   - 8 starts total in frame 2.
5. rst pulsed low mid-RUN.
   - Taps=0, start=0, busy=0 asynchronously.
   - Pixels without sof are ignored.
   - A following clean frame reproduces scenario 1.
6. pix_valid with sof=0 while IDLE: no state change, busy=0, no start or frame_done.

Source files
------------

// File: rtl/cfa_window5x5.sv
// 5x5 Bayer neighbourhood former: four line buffers plus a 5x5 column shift array.
// Emits one registered window per accepted pixel whose window lies fully inside the frame.
module cfa_window5x5 #(
    parameter int PIX_W = 12,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sof,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_in,
    output logic [PIX_W-1:0] e1t1, e1t2, e1t3, e1t4, e1t5,
    output logic [PIX_W-1:0] e2t1, e2t2, e2t3, e2t4, e2t5,
    output logic [PIX_W-1:0] e3t1, e3t2, e3t3, e3t4, e3t5,
    output logic [PIX_W-1:0] e4t1, e4t2, e4t3, e4t4, e4t5,
    output logic [PIX_W-1:0] e5t1, e5t2, e5t3, e5t4, e5t5,
    output logic             start,
    output logic             frame_done,
    output logic             busy,
    output logic [1:0]       fsm_state
);
    // Handshake: a pixel is taken on any cycle with pix_valid=1 while a frame is
    // open, or with sof=1; there is no ready, and start is a one-cycle push downstream.
    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0] COL_FIRST_WIN = COL_W'(4);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0] ROW_FILL_END = ROW_W'(3);
    localparam logic [ROW_W-1:0] ROW_FIRST_WIN = ROW_W'(4);

    state_t           state;
    logic [COL_W-1:0] col, cur_col;
    logic [ROW_W-1:0] row, cur_row;
    logic             restart, accept, last_col, last_pix;
    logic [PIX_W-1:0] lb [0:3][0:IMG_W-1];
    logic [PIX_W-1:0] win [0:4][0:4];
    logic [PIX_W-1:0] col_in [0:4];

    // A sof pixel always lands at (0,0), whatever the counters currently hold.
    always_comb begin
        restart   = pix_valid & sof;
        accept    = pix_valid & (restart | (state == FILL) | (state == RUN));
        cur_col   = restart ? '0 : col;
        cur_row   = restart ? '0 : row;
        last_col  = (cur_col == COL_LAST);
        last_pix  = last_col && (cur_row == ROW_LAST);
        col_in[0] = lb[3][cur_col];
        col_in[1] = lb[2][cur_col];
        col_in[2] = lb[1][cur_col];
        col_in[3] = lb[0][cur_col];
        col_in[4] = pix_in;
    end

    // LB0 holds the previous line, LB3 the line four rows up.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb[0][cur_col] <= pix_in;
            for (int k = 1; k < 4; k++) begin
                lb[k][cur_col] <= lb[k-1][cur_col];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            start      <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 5; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else begin
            start      <= 1'b0;
            frame_done <= 1'b0;
            if (accept) begin
                for (int i = 0; i < 5; i++) begin
                    for (int j = 0; j < 4; j++) begin
                        win[i][j] <= win[i][j+1];
                    end
                    win[i][4] <= col_in[i];
                end
                // Columns 0..3 of a line still carry the previous line's tail in the shift array.
                start      <= (cur_row >= ROW_FIRST_WIN) && (cur_col >= COL_FIRST_WIN);
                frame_done <= last_pix;
                if (last_col) begin
                    col <= '0;
                    row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
                end else begin
                    col <= cur_col + 1'b1;
                    row <= cur_row;
                end
                if (restart) begin
                    state <= FILL;
                    busy  <= 1'b1;
                end else if (state == FILL && cur_row == ROW_FILL_END && last_col) begin
                    state <= RUN;
                end else if (state == RUN && last_pix) begin
                    state <= DONE;
                    busy  <= 1'b0;
                end
            end else if (state == DONE) begin
                state <= IDLE;
            end
        end
    end

    assign fsm_state = state;

    assign e1t1 = win[0][0]; assign e1t2 = win[0][1]; assign e1t3 = win[0][2];
    assign e1t4 = win[0][3]; assign e1t5 = win[0][4];
    assign e2t1 = win[1][0]; assign e2t2 = win[1][1]; assign e2t3 = win[1][2];
    assign e2t4 = win[1][3]; assign e2t5 = win[1][4];
    assign e3t1 = win[2][0]; assign e3t2 = win[2][1]; assign e3t3 = win[2][2];
    assign e3t4 = win[2][3]; assign e3t5 = win[2][4];
    assign e4t1 = win[3][0]; assign e4t2 = win[3][1]; assign e4t3 = win[3][2];
    assign e4t4 = win[3][3]; assign e4t5 = win[3][4];
    assign e5t1 = win[4][0]; assign e5t2 = win[4][1]; assign e5t3 = win[4][2];
    assign e5t4 = win[4][3]; assign e5t5 = win[4][4];

endmodule

// File: tb/tb_cfa_window5x5.sv
// Bench for cfa_window5x5: raster-level image model feeds an expected-window queue,
// a negedge monitor pops and compares whenever start is high.
module tb_cfa_window5x5;
    localparam int PIX_W = 12;
    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int WIN_W = 25 * PIX_W;
    localparam int EXP_W = WIN_W + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sof = 1'b0;
    logic pix_valid = 1'b0;
    logic [PIX_W-1:0] pix_in = '0;
    logic [PIX_W-1:0] e1t1, e1t2, e1t3, e1t4, e1t5, e2t1, e2t2, e2t3, e2t4, e2t5;
    logic [PIX_W-1:0] e3t1, e3t2, e3t3, e3t4, e3t5, e4t1, e4t2, e4t3, e4t4, e4t5;
    logic [PIX_W-1:0] e5t1, e5t2, e5t3, e5t4, e5t5;
    logic start, frame_done, busy;
    logic [1:0] fsm_state;
    logic [WIN_W-1:0] taps;

    always #5 clk = ~clk;

    cfa_window5x5 #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk(clk), .rst(rst), .sof(sof), .pix_valid(pix_valid), .pix_in(pix_in),
        .e1t1(e1t1), .e1t2(e1t2), .e1t3(e1t3), .e1t4(e1t4), .e1t5(e1t5),
        .e2t1(e2t1), .e2t2(e2t2), .e2t3(e2t3), .e2t4(e2t4), .e2t5(e2t5),
        .e3t1(e3t1), .e3t2(e3t2), .e3t3(e3t3), .e3t4(e3t4), .e3t5(e3t5),
        .e4t1(e4t1), .e4t2(e4t2), .e4t3(e4t3), .e4t4(e4t4), .e4t5(e4t5),
        .e5t1(e5t1), .e5t2(e5t2), .e5t3(e5t3), .e5t4(e5t4), .e5t5(e5t5),
        .start(start), .frame_done(frame_done), .busy(busy), .fsm_state(fsm_state)
    );

    assign taps = {e1t1, e1t2, e1t3, e1t4, e1t5, e2t1, e2t2, e2t3, e2t4, e2t5,
                   e3t1, e3t2, e3t3, e3t4, e3t5, e4t1, e4t2, e4t3, e4t4, e4t5,
                   e5t1, e5t2, e5t3, e5t4, e5t5};

    logic [EXP_W-1:0] exp_q[$];
    logic [WIN_W-1:0] seen_q[$];
    logic [EXP_W-1:0] mon_e;
    int n_vec = 0, n_fail = 0, n_start = 0, n_done = 0;
    int start_base = 0, done_base = 0;

    logic [PIX_W-1:0] img [0:IMG_H-1][0:IMG_W-1];
    bit in_frame = 0, hold_known = 0, gap_pending = 0;
    int mr = 0, mc = 0;
    logic [WIN_W-1:0] hold_win = '0;

    function automatic logic [PIX_W-1:0] tap_of(input logic [WIN_W-1:0] w, input int i, input int j);
        return w[(24 - (i * 5 + j)) * PIX_W +: PIX_W];
    endfunction

    function automatic logic [PIX_W-1:0] seen_tap(input int k, input int i, input int j);
        if (k >= seen_q.size()) return 'x;
        return tap_of(seen_q[k], i, j);
    endfunction

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: every pixel of the frame lands in img[row][col]; a window exists
    // for any pixel at row>=4, col>=4 and is simply the 5x5 block ending there.
    task automatic model_step(input bit s, input bit v, input logic [PIX_W-1:0] p);
        logic [WIN_W-1:0] w;
        bit last;
        if (!v) return;
        if (s) begin
            in_frame = 1; mr = 0; mc = 0;
        end else if (!in_frame) begin
            return;
        end
        img[mr][mc] = p;
        if (mr >= 4 && mc >= 4) begin
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    w[(24 - (i * 5 + j)) * PIX_W +: PIX_W] = img[mr - 4 + i][mc - 4 + j];
            last = (mr == IMG_H - 1) && (mc == IMG_W - 1);
            exp_q.push_back({last, w});
            hold_win = w;
            hold_known = 1;
        end else begin
            hold_known = 0;
        end
        if (mc == IMG_W - 1) begin
            mc = 0;
            if (mr == IMG_H - 1) in_frame = 0;
            else mr++;
        end else begin
            mc++;
        end
    endtask

    task automatic drive(input bit s, input bit v, input logic [PIX_W-1:0] p);
        @(negedge clk);
        if (gap_pending) begin
            check_val("gap_start", start, 0);
            if (hold_known) begin
                n_vec++;
                if (taps !== hold_win) begin
                    n_fail++;
                    $display("FAIL gap_hold: got %h, expected %h", taps, hold_win);
                end
            end
        end
        sof = s; pix_valid = v; pix_in = p;
        model_step(s, v, p);
        gap_pending = !v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, '0);
    endtask

    // gap_mode 0: continuous, 1: pixel then two idle cycles, 2: random idle runs.
    task automatic send_frame(input int base, input int gap_mode, input bit rand_pix, input int n_pix);
        for (int idx = 0; idx < n_pix; idx++) begin
            int r, c;
            logic [PIX_W-1:0] p;
            r = idx / IMG_W;
            c = idx % IMG_W;
            p = rand_pix ? PIX_W'($urandom) : PIX_W'(base | (r << 4) | c);
            drive(idx == 0, 1, p);
            if (idx == 10) check_val("busy_mid_frame", busy, 1);
            if (gap_mode == 1) idle(2);
            else if (gap_mode == 2 && $urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
        end
    endtask

    task automatic begin_phase();
        seen_q.delete();
        start_base = n_start;
        done_base = n_done;
    endtask

    task automatic check_pattern_frame(input string tag, input int base);
        check_val({tag, "_starts"}, n_start - start_base, 8);
        check_val({tag, "_done"}, n_done - done_base, 1);
        check_val({tag, "_w0_e1t1"}, seen_tap(0, 0, 0), base | 12'h000);
        check_val({tag, "_w0_e3t3"}, seen_tap(0, 2, 2), base | 12'h022);
        check_val({tag, "_w0_e5t5"}, seen_tap(0, 4, 4), base | 12'h044);
        check_val({tag, "_w0_e1t5"}, seen_tap(0, 0, 4), base | 12'h004);
        check_val({tag, "_w0_e5t1"}, seen_tap(0, 4, 0), base | 12'h040);
        check_val({tag, "_wrap_e1t1"}, seen_tap(4, 0, 0), base | 12'h010);
        check_val({tag, "_wrap_e5t5"}, seen_tap(4, 4, 4), base | 12'h054);
        check_val({tag, "_last_e5t5"}, seen_tap(7, 4, 4), base | 12'h057);
    endtask

    always @(negedge clk) begin
        if (start === 1'b1) begin
            n_start++;
            seen_q.push_back(taps);
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_start: got start=1 with taps %h, expected no window", taps);
            end else begin
                mon_e = exp_q.pop_front();
                if (taps !== mon_e[WIN_W-1:0]) begin
                    n_fail++;
                    $display("FAIL window: got %h, expected %h", taps, mon_e[WIN_W-1:0]);
                end
                n_vec++;
                if (frame_done !== mon_e[WIN_W]) begin
                    n_fail++;
                    $display("FAIL frame_done_with_window: got %b, expected %b", frame_done, mon_e[WIN_W]);
                end
            end
        end else begin
            n_vec++;
            if (frame_done !== 1'b0) begin
                n_fail++;
                $display("FAIL stray_frame_done: got %b, expected 0", frame_done);
            end
        end
        if (frame_done === 1'b1) n_done++;
    end

    initial begin
        repeat (2) @(negedge clk);
        check_val("reset_taps_zero", (taps == '0) ? 32'd1 : 32'd0, 1);
        check_val("reset_start", start, 0);
        check_val("reset_busy", busy, 0);
        check_val("reset_frame_done", frame_done, 0);
        check_val("reset_state", fsm_state, 0);
        rst = 1'b1;

        // pixels without sof while idle are ignored
        begin_phase();
        for (int i = 0; i < 12; i++) drive(0, 1, PIX_W'($urandom));
        idle(2);
        check_val("idle_busy", busy, 0);
        check_val("idle_state", fsm_state, 0);
        check_val("idle_no_start", n_start - start_base, 0);
        check_val("idle_no_done", n_done - done_base, 0);

        begin_phase();
        send_frame(0, 0, 0, IMG_W * IMG_H);
        idle(3);
        check_pattern_frame("cont", 0);

        begin_phase();
        send_frame(0, 1, 0, IMG_W * IMG_H);
        idle(3);
        check_pattern_frame("gappy", 0);

        // abort frame 1 at pixel 20 with a new sof
        begin_phase();
        send_frame(0, 0, 0, 20);
        send_frame(12'h800, 0, 0, IMG_W * IMG_H);
        idle(3);
        check_pattern_frame("abort", 12'h800);

        // reset deep in RUN, checked before the next clock edge
        begin_phase();
        send_frame(0, 0, 0, 38);
        idle(2);
        check_val("pre_reset_busy", busy, 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_val("async_taps_zero", (taps == '0) ? 32'd1 : 32'd0, 1);
        check_val("async_start", start, 0);
        check_val("async_busy", busy, 0);
        in_frame = 0; hold_known = 0; gap_pending = 0;
        @(negedge clk);
        rst = 1'b1;
        begin_phase();
        for (int i = 0; i < 10; i++) drive(0, 1, PIX_W'($urandom));
        idle(2);
        check_val("post_reset_ignored_starts", n_start - start_base, 0);
        check_val("post_reset_busy", busy, 0);
        begin_phase();
        send_frame(0, 0, 0, IMG_W * IMG_H);
        idle(3);
        check_pattern_frame("after_rst", 0);

        // random pixels and random idle runs, checked by the model alone
        for (int f = 0; f < 3; f++) begin
            begin_phase();
            send_frame(0, 2, 1, IMG_W * IMG_H);
            idle(3);
            check_val("rand_starts", n_start - start_base, 8);
            check_val("rand_done", n_done - done_base, 1);
        end

        idle(3);
        check_val("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
